// File: rtl/divider_iter_counter.sv
// Iteration counter for the iterative divider loop. It counts while the FSM is
// iterating, the FSM clears it on load/start, and zC tells the FSM the loop is done.
module divider_iter_counter #(
  parameter int WIDTH    = 3,
  parameter int TERMINAL = (1 << WIDTH) - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             E,
  input  logic             sclr,
  output logic [WIDTH-1:0] Q,
  output logic             zC
);

  localparam logic [WIDTH-1:0] TERM_Q = TERMINAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE_Q  = {{(WIDTH-1){1'b0}}, 1'b1};

  generate
    if (WIDTH < 1 || TERMINAL < 0 || TERMINAL > (1 << WIDTH) - 1) begin : g_bad_param
      $error("divider_iter_counter: TERMINAL must fit in WIDTH bits");
    end
  endgenerate

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Clear beats enable; the increment wraps naturally at 2**WIDTH.
  always_comb begin
    cnt_d = cnt_q;
    if (sclr) begin
      cnt_d = '0;
    end else if (E) begin
      cnt_d = cnt_q + ONE_Q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign Q  = cnt_q;
  assign zC = (cnt_q == TERM_Q);

endmodule

// File: tb/tb_divider_iter_counter.sv
// Bench for divider_iter_counter: directed steps push the expected {Q,zC} into a
// queue stamped with the edge they apply after; a negedge monitor pops and compares.
module tb_divider_iter_counter;

  localparam int WIDTH = 3;
  localparam int SW    = 16;
  localparam int W     = SW + WIDTH + 1;

  logic             clk;
  logic             reset;
  logic             E;
  logic             sclr;
  logic [WIDTH-1:0] Q;
  logic             zC;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           cyc;
  int           n_pass;
  int           n_total;

  divider_iter_counter #(.WIDTH(WIDTH), .TERMINAL(7)) dut (
    .clk  (clk),
    .reset(reset),
    .E    (E),
    .sclr (sclr),
    .Q    (Q),
    .zC   (zC)
  );

  // clock / reset block
  initial begin
    clk   = 1'b0;
    reset = 1'b0;
    E     = 1'b0;
    sclr  = 1'b0;
  end
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  initial cyc = 0;

  task automatic check(input string name, input logic [WIDTH-1:0] act_q, input logic act_z,
                       input logic [WIDTH-1:0] req_q, input logic req_z);
    n_total++;
    if ({act_q, act_z} === {req_q, req_z}) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got Q=%0d zC=%b, expected Q=%0d zC=%b", name, act_q, act_z, req_q, req_z);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    while (exp_q.size() > 0 && int'(exp_q[0][W-1 -: SW]) <= cyc) begin
      logic [W-1:0] e;
      string        nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check(nm, Q, zC, e[WIDTH:1], e[0]);
    end
  end

  // driver: called at a negedge; expectation applies after the coming posedge
  task automatic step(input string name, input logic e, input logic s,
                      input int req_q, input logic req_z);
    logic [SW-1:0]    stamp;
    logic [WIDTH-1:0] rq;
    stamp = SW'(cyc + 1);
    rq    = WIDTH'(req_q);
    E     = e;
    sclr  = s;
    exp_q.push_back({stamp, rq, req_z});
    name_q.push_back(name);
    @(negedge clk);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    @(negedge clk);
    check("reset_initial", Q, zC, 3'd0, 1'b0);

    step("reset_hold0", 1'b1, 1'b0, 0, 1'b0);
    step("reset_hold1", 1'b1, 1'b0, 0, 1'b0);
    reset = 1'b1;

    for (int k = 1; k <= 20; k++) begin
      step("free_count", 1'b1, 1'b0, k % 8, (k % 8) == 7);
    end

    for (int k = 0; k < 5; k++) step("sclr_priority", 1'b1, 1'b1, 0, 1'b0);
    step("sclr_release", 1'b1, 1'b0, 1, 1'b0);
    step("count_2", 1'b1, 1'b0, 2, 1'b0);
    step("count_3", 1'b1, 1'b0, 3, 1'b0);

    for (int k = 0; k < 5; k++) step("hold_at_3", 1'b0, 1'b0, 3, 1'b0);
    step("reenable", 1'b1, 1'b0, 4, 1'b0);
    step("count_5", 1'b1, 1'b0, 5, 1'b0);
    step("count_6", 1'b1, 1'b0, 6, 1'b0);

    step("hold_at_6", 1'b0, 1'b0, 6, 1'b0);
    step("clr_disabled", 1'b0, 1'b1, 0, 1'b0);
    step("clr_with_e0", 1'b1, 1'b1, 0, 1'b0);
    step("clr_with_e1", 1'b1, 1'b1, 0, 1'b0);
    for (int k = 1; k <= 7; k++) step("resume_count", 1'b1, 1'b0, k, k == 7);

    for (int k = 0; k < 3; k++) step("terminal_hold", 1'b0, 1'b0, 7, 1'b1);
    step("terminal_clr", 1'b0, 1'b1, 0, 1'b0);

    for (int k = 1; k <= 5; k++) step("count_to_5", 1'b1, 1'b0, k, 1'b0);

    // asynchronous reset mid-cycle at Q=5
    #2 reset = 1'b0;
    #1 check("async_reset", Q, zC, 3'd0, 1'b0);
    @(negedge clk);
    step("reset_low_e1", 1'b1, 1'b0, 0, 1'b0);
    reset = 1'b1;
    step("after_reset", 1'b1, 1'b0, 1, 1'b0);
    step("after_reset2", 1'b1, 1'b0, 2, 1'b0);

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expected entries never compared, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/divider_iter_counter.md
Name: divider_iter_counter

Overview:
- Iteration counter for the iterative divider datapath.
- Counts clock cycles while enabled, can be synchronously cleared by the controller, and flags the terminal iteration so the FSM knows when the division loop is done.
- Sits beside the divider control FSM: E comes from the FSM "iterate" state, sclr from its "load/start" state, and zC feeds back to the FSM.

Parameters:
- WIDTH, 3, counter width in bits; width of Q.
- TERMINAL, 2**WIDTH-1 (7), count value at which zC asserts; must be within 0..2**WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous reset, active-low; port is named reset. reset=0 clears the counter immediately, independent of clk.
- E  input  1  count enable; sampled on rising clk edge.
- sclr  input  1  synchronous clear; sampled on rising clk edge.
- Q  output  WIDTH  current count (registered).
- zC  output  1  terminal-count flag; combinational decode of Q.

Behaviour:
- Reset:
  - reset=0 forces Q=0 asynchronously and holds it while low; zC=0 during reset (TERMINAL != 0 by default).
  - Release of reset takes effect at the next rising edge evaluation; no counting occurs while reset=0.
- Per rising clk edge, with reset=1, priority is:
  - sclr=1: Q <= 0, regardless of E.
  - else if E=1: Q <= Q+1 modulo 2**WIDTH. 7 wraps to 0 for WIDTH=3; no saturation; no carry out.
  - else: Q holds.
- Output flag:
  - zC = (Q == TERMINAL), purely combinational from registered Q; no extra latency.
  - With E held high from Q=0, zC asserts on the 8th cycle (Q=7) for exactly one cycle, then deasserts as Q wraps to 0.
- Latency: Q reflects an E or sclr change after exactly one rising edge; zC follows Q in the same cycle.
- Simultaneous events:
  - sclr=1 with E=1 clears to 0 (clear wins).
  - sclr=1 while Q=TERMINAL clears to 0; zC drops in the same cycle Q becomes 0.
- sclr held high keeps Q=0 across any number of cycles.
- When sclr is released with E=1, counting resumes from 0 on the next edge: 0 then 1.
- E=0 freezes Q at its current value indefinitely; zC remains at its decoded value.
- Reset asserted mid-count (any Q) returns Q to 0 immediately, with no glitch requirement on Q beyond going to 0.
- All outputs must be known (no X) after the first reset assertion.
- Inputs are assumed synchronous to clk; no internal synchronizers.

Test Plan:
- Reset: reset=0 for 2 cycles with E=1 -> Q=0, zC=0 throughout. Assert reset=0 asynchronously mid-cycle when Q=5 -> Q=0 before the next edge.
- Free count: reset=1, E=1, sclr=0 for 20 edges -> Q sequence 1,2,...,7,0,1,...; zC=1 only in cycles where Q=7; wrap 7->0 observed twice.
- Sync clear priority: while counting at Q=4, set sclr=1 and E=1 for 5 cycles -> Q=0 from the first edge and held; release sclr -> Q=1 after the next edge.
- Hold: at Q=3 drop E to 0 for 5 cycles -> Q stays 3, zC=0. Re-enable -> Q=4.
- Clear while disabled: E=0, Q=6, then sclr=1 -> Q=0 next edge. Then E=1 with sclr still 1 -> Q stays 0. Drop sclr -> Q counts 1,2,...
- Terminal flag: count to Q=7 with E=1 (zC=1), then E=0 for 3 cycles -> zC stays 1. Then sclr=1 -> Q=0, zC=0.
